// File: rtl/hazard3_regfile_ctrl_if.sv
// Bus between the core / register file and the register-file control stage.
// master: the core and the register file; slave: the control stage.
interface hazard3_regfile_ctrl_if #(
  parameter int W_DATA = 32,
  parameter int W_ADDR = 5
);
  logic              clear_req;
  logic              ready;
  logic [W_ADDR-1:0] core_raddr1;
  logic [W_ADDR-1:0] core_raddr2;
  logic [W_DATA-1:0] core_rdata1;
  logic [W_DATA-1:0] core_rdata2;
  logic [W_ADDR-1:0] core_waddr;
  logic [W_DATA-1:0] core_wdata;
  logic              core_wen;
  logic [W_ADDR-1:0] rf_raddr1;
  logic [W_ADDR-1:0] rf_raddr2;
  logic [W_DATA-1:0] rf_rdata1;
  logic [W_DATA-1:0] rf_rdata2;
  logic [W_ADDR-1:0] rf_waddr;
  logic [W_DATA-1:0] rf_wdata;
  logic              rf_wen;

  modport master (
    output clear_req, core_raddr1, core_raddr2, core_waddr, core_wdata, core_wen,
           rf_rdata1, rf_rdata2,
    input  ready, core_rdata1, core_rdata2, rf_raddr1, rf_raddr2, rf_waddr,
           rf_wdata, rf_wen
  );

  modport slave (
    input  clear_req, core_raddr1, core_raddr2, core_waddr, core_wdata, core_wen,
           rf_rdata1, rf_rdata2,
    output ready, core_rdata1, core_rdata2, rf_raddr1, rf_raddr2, rf_waddr,
           rf_wdata, rf_wen
  );
endinterface

// File: rtl/hazard3_regfile_ctrl.sv
// Control stage in front of a no-reset dual-read register file: post-reset wipe,
// x0 hardwiring and same-cycle write-to-read bypass.
module hazard3_regfile_ctrl #(
  parameter int                N_REGS     = 32,
  parameter int                W_DATA     = 32,
  parameter int                W_ADDR     = 5,
  parameter logic [W_DATA-1:0] INIT_VALUE = '0
) (
  input logic                    clk,
  input logic                    rst_n,
  hazard3_regfile_ctrl_if.slave  bus
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [W_ADDR-1:0] LAST_ADDR = W_ADDR'(N_REGS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [W_ADDR-1:0] clr_cnt;
  logic [W_ADDR-1:0] clr_cnt_nxt;
  logic              core_wr_ok;
  logic              zero1_p1;
  logic              zero2_p1;
  logic              hit1_p1;
  logic              hit2_p1;
  logic [W_DATA-1:0] byp_data_p1;

  // x0 is never a real write target
  assign core_wr_ok = bus.core_wen && (bus.core_waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_cnt_nxt  = clr_cnt;
    bus.rf_wen   = 1'b0;
    bus.rf_waddr = bus.core_waddr;
    bus.rf_wdata = bus.core_wdata;
    case (state)
      CLEAR: begin
        bus.rf_wen   = 1'b1;
        bus.rf_waddr = clr_cnt;
        bus.rf_wdata = INIT_VALUE;
        if (clr_cnt == LAST_ADDR) begin
          state_nxt   = RUN;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      RUN: begin
        bus.rf_wen = core_wr_ok;
        // The write issued alongside clear_req still lands; the wipe follows it
        if (bus.clear_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  assign bus.ready     = (state == RUN);
  assign bus.rf_raddr1 = bus.core_raddr1;
  assign bus.rf_raddr2 = bus.core_raddr2;

  // Stage p1: read-select flags aligned with the register file's registered read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero1_p1 <= 1'b1;
      zero2_p1 <= 1'b1;
      hit1_p1  <= 1'b0;
      hit2_p1  <= 1'b0;
    end else begin
      zero1_p1 <= (bus.core_raddr1 == '0) || (state == CLEAR);
      zero2_p1 <= (bus.core_raddr2 == '0) || (state == CLEAR);
      hit1_p1  <= (state == RUN) && core_wr_ok && (bus.core_waddr == bus.core_raddr1);
      hit2_p1  <= (state == RUN) && core_wr_ok && (bus.core_waddr == bus.core_raddr2);
    end
  end

  always_ff @(posedge clk) begin
    byp_data_p1 <= bus.core_wdata;
  end

  assign bus.core_rdata1 = zero1_p1 ? '0 : hit1_p1 ? byp_data_p1 : bus.rf_rdata1;
  assign bus.core_rdata2 = zero2_p1 ? '0 : hit2_p1 ? byp_data_p1 : bus.rf_rdata2;

endmodule

// File: tb/tb_hazard3_regfile_ctrl.sv
// Directed bench for hazard3_regfile_ctrl with a behavioural register file that
// powers up with garbage and has registered reads.
module tb_hazard3_regfile_ctrl;
  localparam int N_REGS = 32;
  localparam int W_DATA = 32;
  localparam int W_ADDR = 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hazard3_regfile_ctrl_if #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) bus ();

  hazard3_regfile_ctrl #(
    .N_REGS(N_REGS), .W_DATA(W_DATA), .W_ADDR(W_ADDR), .INIT_VALUE(32'h0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: no reset, garbage contents until written
  logic [31:0] mem [0:31];
  logic [31:0] rd1_q;
  logic [31:0] rd2_q;
  logic        force1;
  bit          seeded = 1'b0;

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hBAD0_0000 | i;
      seeded <= 1'b1;
    end else if (bus.rf_wen) begin
      mem[bus.rf_waddr] <= bus.rf_wdata;
    end
    rd1_q <= mem[bus.rf_raddr1];
    rd2_q <= mem[bus.rf_raddr2];
  end

  assign bus.rf_rdata1 = force1 ? 32'hFFFF_FFFF : rd1_q;
  assign bus.rf_rdata2 = rd2_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.core_rdata1 !== 32'h0 || bus.core_rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_state ready=%b rdata1=%h rdata2=%h required 0/0/0",
               bus.ready, bus.core_rdata1, bus.core_rdata2);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < N_REGS; i++) begin
      checks++;
      if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'(i) || bus.rf_wdata !== 32'h0 ||
          bus.ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_sweep cyc=%0d wen=%b waddr=%0d wdata=%h ready=%b required 1/%0d/0/0",
                 i, bus.rf_wen, bus.rf_waddr, bus.rf_wdata, bus.ready, i);
      end
      tick();
    end
    checks++;
    if (bus.ready !== 1'b1 || bus.rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready ready=%b rf_wen=%b required 1/0", bus.ready, bus.rf_wen);
    end
    for (int a = 1; a < 32; a += 6) begin
      bus.core_raddr1 = 5'(a);
      bus.core_raddr2 = 5'(31 - a);
      tick();
      checks++;
      if (bus.core_rdata1 !== 32'h0 || bus.core_rdata2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_read a=%0d rdata1=%h rdata2=%h required 0/0",
                 a, bus.core_rdata1, bus.core_rdata2);
      end
    end
  endtask

  task automatic test_bypass();
    bus.core_waddr  = 5'd5;
    bus.core_wdata  = 32'hDEAD_BEEF;
    bus.core_wen    = 1'b1;
    bus.core_raddr1 = 5'd5;
    bus.core_raddr2 = 5'd5;
    #1;
    checks++;
    if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_wr wen=%b waddr=%0d wdata=%h required 1/5/deadbeef",
               bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.core_rdata1 !== 32'hDEAD_BEEF || bus.core_rdata2 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_same rdata1=%h rdata2=%h required deadbeef",
               bus.core_rdata1, bus.core_rdata2);
    end
    bus.core_wen    = 1'b0;
    bus.core_raddr1 = 5'd0;
    bus.core_raddr2 = 5'd0;
    tick();
    bus.core_raddr1 = 5'd5;
    bus.core_raddr2 = 5'd5;
    tick();
    checks++;
    if (bus.core_rdata1 !== 32'hDEAD_BEEF || bus.core_rdata2 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_later rdata1=%h rdata2=%h required deadbeef",
               bus.core_rdata1, bus.core_rdata2);
    end
  endtask

  task automatic test_back_to_back();
    bus.core_waddr = 5'd10;
    bus.core_wdata = 32'h0000_0A0A;
    bus.core_wen   = 1'b1;
    tick();
    bus.core_waddr  = 5'd11;
    bus.core_wdata  = 32'h0000_0B0B;
    bus.core_raddr1 = 5'd10;
    bus.core_raddr2 = 5'd11;
    tick();
    bus.core_wen = 1'b0;
    checks++;
    if (bus.core_rdata1 !== 32'h0000_0A0A || bus.core_rdata2 !== 32'h0000_0B0B) begin
      errors++;
      $display("FAIL back_to_back rdata1=%h rdata2=%h required 00000a0a/00000b0b",
               bus.core_rdata1, bus.core_rdata2);
    end
  endtask

  task automatic test_x0();
    bus.core_waddr  = 5'd0;
    bus.core_wdata  = 32'h1234_5678;
    bus.core_wen    = 1'b1;
    bus.core_raddr1 = 5'd0;
    bus.core_raddr2 = 5'd0;
    #1;
    checks++;
    if (bus.rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL x0_wen rf_wen=%b required 0", bus.rf_wen);
    end
    @(posedge clk);
    #1;
    bus.core_wen = 1'b0;
    checks++;
    if (bus.core_rdata1 !== 32'h0 || bus.core_rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL x0_same rdata1=%h rdata2=%h required 0/0", bus.core_rdata1, bus.core_rdata2);
    end
    force1 = 1'b1;
    tick();
    checks++;
    if (bus.core_rdata1 !== 32'h0 || bus.core_rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL x0_forced rdata1=%h rdata2=%h required 0/0", bus.core_rdata1, bus.core_rdata2);
    end
    bus.core_raddr1 = 5'd5;
    tick();
    checks++;
    if (bus.core_rdata1 !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL rf_passthru rdata1=%h required ffffffff", bus.core_rdata1);
    end
    force1 = 1'b0;
    bus.core_raddr1 = 5'd0;
  endtask

  task automatic test_clear_req();
    for (int a = 1; a < 32; a++) begin
      bus.core_wen   = 1'b1;
      bus.core_waddr = 5'(a);
      bus.core_wdata = 32'h1000_0000 + a;
      tick();
    end
    bus.core_wen    = 1'b0;
    bus.core_raddr1 = 5'd9;
    bus.core_raddr2 = 5'd31;
    tick();
    checks++;
    if (bus.core_rdata1 !== 32'h1000_0009 || bus.core_rdata2 !== 32'h1000_001F) begin
      errors++;
      $display("FAIL fill_read rdata1=%h rdata2=%h required 10000009/1000001f",
               bus.core_rdata1, bus.core_rdata2);
    end
    bus.clear_req  = 1'b1;
    bus.core_wen   = 1'b1;
    bus.core_waddr = 5'd3;
    bus.core_wdata = 32'h0000_00AA;
    #1;
    checks++;
    if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'hAA ||
        bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_wr wen=%b waddr=%0d wdata=%h ready=%b required 1/3/aa/1",
               bus.rf_wen, bus.rf_waddr, bus.rf_wdata, bus.ready);
    end
    @(posedge clk);
    #1;
    bus.clear_req = 1'b0;
    bus.core_wen  = 1'b0;
    checks++;
    if (mem[3] !== 32'hAA) begin
      errors++;
      $display("FAIL clr_wr_land mem3=%h required aa", mem[3]);
    end
    for (int i = 0; i < N_REGS; i++) begin
      checks++;
      if (bus.ready !== 1'b0 || bus.rf_waddr !== 5'(i)) begin
        errors++;
        $display("FAIL clr_sweep cyc=%0d ready=%b waddr=%0d required 0/%0d",
                 i, bus.ready, bus.rf_waddr, i);
      end
      tick();
    end
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_ready ready=%b required 1", bus.ready);
    end
    for (int a = 0; a < 32; a += 2) begin
      bus.core_raddr1 = 5'(a);
      bus.core_raddr2 = 5'(a + 1);
      tick();
      checks++;
      if (bus.core_rdata1 !== 32'h0 || bus.core_rdata2 !== 32'h0) begin
        errors++;
        $display("FAIL clr_read a=%0d rdata1=%h rdata2=%h required 0/0",
                 a, bus.core_rdata1, bus.core_rdata2);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    repeat (17) tick();
    checks++;
    if (bus.rf_waddr !== 5'd17 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_cnt waddr=%0d ready=%b required 17/0", bus.rf_waddr, bus.ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rf_waddr !== 5'd0 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst waddr=%0d ready=%b required 0/0", bus.rf_waddr, bus.ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < N_REGS; i++) begin
      checks++;
      if (bus.ready !== 1'b0 || bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'(i)) begin
        errors++;
        $display("FAIL mid_sweep cyc=%0d ready=%b wen=%b waddr=%0d required 0/1/%0d",
                 i, bus.ready, bus.rf_wen, bus.rf_waddr, i);
      end
      tick();
    end
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_ready ready=%b required 1", bus.ready);
    end
  endtask

  task automatic test_write_during_clear();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    repeat (20) tick();
    bus.core_wen    = 1'b1;
    bus.core_waddr  = 5'd7;
    bus.core_wdata  = 32'h0000_0055;
    bus.core_raddr1 = 5'd7;
    #1;
    checks++;
    if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd20 || bus.rf_wdata !== 32'h0) begin
      errors++;
      $display("FAIL drop_wr wen=%b waddr=%0d wdata=%h required 1/20/0",
               bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
    end
    @(posedge clk);
    #1;
    bus.core_wen = 1'b0;
    checks++;
    if (bus.core_rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL drop_byp rdata1=%h required 0", bus.core_rdata1);
    end
    repeat (11) tick();
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL drop_ready ready=%b required 1", bus.ready);
    end
    bus.core_raddr1 = 5'd7;
    tick();
    checks++;
    if (bus.core_rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL drop_read rdata1=%h required 0", bus.core_rdata1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    checks          = 0;
    errors          = 0;
    force1          = 1'b0;
    rst_n           = 1'b0;
    bus.clear_req   = 1'b0;
    bus.core_raddr1 = '0;
    bus.core_raddr2 = '0;
    bus.core_waddr  = '0;
    bus.core_wdata  = '0;
    bus.core_wen    = 1'b0;
    test_reset();
    test_bypass();
    test_back_to_back();
    test_x0();
    test_clear_req();
    test_reset_mid_clear();
    test_write_during_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard3_regfile_ctrl.md
# hazard3_regfile_ctrl

Control stage between the core's decode/writeback logic and the no-reset dual-read register file. Wipes every register to a known value after reset or on request, since the register file has no reset of its own. Keeps x0 hardwired to zero on both the write and read paths. Adds write-to-read bypass so a read issued in the same cycle as a write to that address returns the new data, because the register file provides no read-during-write guarantee.

## Interface
Parameters:
- N_REGS, 32: number of architectural registers cleared and addressed.
- W_DATA, 32: data width.
- W_ADDR, 5: register address width; 2^W_ADDR >= N_REGS.
- INIT_VALUE, 0: W_DATA-bit value written to every register during clear.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clear_req  in  1  single-cycle request to re-clear the register file; honoured only while ready=1.
- ready  out  1  high when the core may issue reads and writes.
- core_raddr1  in  W_ADDR  read address, port 1.
- core_raddr2  in  W_ADDR  read address, port 2.
- core_rdata1  out  W_DATA  read data, port 1, one cycle after its address.
- core_rdata2  out  W_DATA  read data, port 2, one cycle after its address.
- core_waddr  in  W_ADDR  write address.
- core_wdata  in  W_DATA  write data.
- core_wen  in  1  write enable.
- rf_raddr1  out  W_ADDR  read address 1 to the register file.
- rf_raddr2  out  W_ADDR  read address 2 to the register file.
- rf_rdata1  in  W_DATA  registered read data 1 from the register file.
- rf_rdata2  in  W_DATA  registered read data 2 from the register file.
- rf_waddr  out  W_ADDR  write address to the register file.
- rf_wdata  out  W_DATA  write data to the register file.
- rf_wen  out  1  write enable to the register file.

## Operation
- States: CLEAR and RUN. W_ADDR-bit counter clr_cnt.
- Reset: state=CLEAR, clr_cnt=0, ready=0, hit1=hit2=0, zero1=zero2=1, so core_rdata1/2 = 0.
- CLEAR:
  - rf_wen=1, rf_waddr=clr_cnt, rf_wdata=INIT_VALUE.
  - clr_cnt increments each cycle.
  - When clr_cnt==N_REGS-1, the next state is RUN and clr_cnt returns to 0.
  - core_wen and clear_req are ignored. Core writes are dropped, not queued.
  - Writes to address 0 during reset assertion are benign.
- RUN:
  - rf_wen = core_wen && core_waddr!=0; rf_waddr/rf_wdata = core_waddr/core_wdata.
  - clear_req=1 moves to CLEAR on the next edge. A core write in that same cycle is still performed.
- Reads:
  - rf_raddrN = core_raddrN, combinational, in all states.
  - Each edge registers:
    - zeroN = (core_raddrN==0) || state==CLEAR.
    - hitN = state==RUN && core_wen && core_waddr!=0 && core_waddr==core_raddrN.
    - byp_data = core_wdata, one register shared by both ports.
  - core_rdataN = zeroN ? 0 : hitN ? byp_data : rf_rdataN.
  - Both ports may hit the same write simultaneously.
- x0: never written by the core and never bypassed. It always reads 0 regardless of register file contents.

## Timing
- Read latency: 1 cycle, matching the register file.
- Write visible to a same-cycle read via bypass. Visible from the register file on any later read.
- Clear duration: exactly N_REGS cycles. After reset release, the edges numbered 1..N_REGS write addresses 0..N_REGS-1. ready rises after edge N_REGS.
- clear_req accepted at edge k: ready=0 from k through k+N_REGS-1, ready=1 after edge k+N_REGS.
- Reset asserted mid-clear: state returns to CLEAR with clr_cnt=0, and the wipe restarts from address 0.
- ready is a registered function of state only, with no combinational path from inputs.

## Test plan
- Reset release, default parameters: rf_wen=1 for 32 consecutive cycles with rf_waddr=0..31 and rf_wdata=0. ready rises on cycle 32. Every subsequent read returns 0.
- RUN, write x5=0xDEADBEEF with core_raddr1=5 and core_raddr2=5 in the same cycle: both core_rdata1 and core_rdata2 are 0xDEADBEEF next cycle. A read of x5 two cycles later also returns 0xDEADBEEF.
- Write x0=0x12345678: rf_wen=0. A same-cycle read of x0 and a later read of x0 both return 0. Also force rf_rdata1=0xFFFFFFFF on a read of x0: core_rdata1=0.
- Fill x1..x31 with nonzero values, pulse clear_req together with a write x3=0xAA: the x3 write reaches the register file. ready is low for 32 cycles. Afterwards all registers read 0.
- Assert rst_n low at clr_cnt=17, release: the clear restarts at rf_waddr=0, and ready rises 32 cycles after release.
- Issue core_wen during CLEAR to x7=0x55: the write is dropped. x7 reads INIT_VALUE after ready rises.
